// File: rtl/stdp_update_arbiter.sv
// stdp_update_arbiter: round-robin scheduler sharing one STDP weight-update engine among N_SYN synapses
// Ports: clk/rst_n (async active-low); pre_spike/post_spike per-synapse 1-cycle pulses;
//        cmd_valid/cmd_ready handshake carrying cmd_idx, cmd_pot (1=potentiate), cmd_dt;
//        busy = any slot pending or command outstanding; drop_cnt = overwritten-event count.
// Define STDP_ARB_DROPCNT_EN to build the saturating drop_cnt counter; otherwise drop_cnt is 0.
module stdp_update_arbiter #(
    parameter int N_SYN    = 4,
    parameter int IDX_W    = 2,
    parameter int DT_WIDTH = 8,
    parameter int WINDOW   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_SYN-1:0]    pre_spike,
    input  logic [N_SYN-1:0]    post_spike,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [IDX_W-1:0]    cmd_idx,
    output logic                cmd_pot,
    output logic [DT_WIDTH-1:0] cmd_dt,
    output logic                busy,
    output logic [7:0]          drop_cnt
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;
    localparam logic [DT_WIDTH-1:0] ONES = '1;
    localparam logic [DT_WIDTH-1:0] WIN  = DT_WIDTH'(WINDOW);

    logic [DT_WIDTH-1:0] t_pre_q [N_SYN];
    logic [DT_WIDTH-1:0] t_pre_d [N_SYN];
    logic [DT_WIDTH-1:0] t_post_q [N_SYN];
    logic [DT_WIDTH-1:0] t_post_d [N_SYN];
    logic [DT_WIDTH-1:0] slot_dt_q [N_SYN];
    logic [DT_WIDTH-1:0] slot_dt_d [N_SYN];
    logic [DT_WIDTH-1:0] ev_dt [N_SYN];
    logic [N_SYN-1:0]    slot_v_q, slot_v_d, slot_pot_q, slot_pot_d, ev, ev_pot;
    logic [0:0]          state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d, cmd_idx_q, cmd_idx_d, gnt_idx, cand;
    logic                gnt_found, grant, cmd_pot_q, cmd_pot_d;
    logic [DT_WIDTH-1:0] cmd_dt_q, cmd_dt_d;

    always_comb begin
        for (int i = 0; i < N_SYN; i++) begin
            t_pre_d[i]  = pre_spike[i]  ? DT_WIDTH'(1) : (t_pre_q[i]  == ONES ? ONES : t_pre_q[i]  + DT_WIDTH'(1));
            t_post_d[i] = post_spike[i] ? DT_WIDTH'(1) : (t_post_q[i] == ONES ? ONES : t_post_q[i] + DT_WIDTH'(1));
            // simultaneous pre+post is a zero-delay potentiation regardless of timers
            ev_pot[i] = post_spike[i] && (pre_spike[i] || t_pre_q[i] < WIN);
            ev[i]     = ev_pot[i] || (pre_spike[i] && t_post_q[i] < WIN);
            ev_dt[i]  = pre_spike[i] ? (post_spike[i] ? '0 : t_post_q[i]) : t_pre_q[i];
        end
    end

    // round-robin search starting just after the last grant; index wraps since N_SYN = 2^IDX_W
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last_q;
        cand      = '0;
        for (int k = 0; k < N_SYN; k++) begin
            cand = last_q + IDX_W'(k + 1);
            if (!gnt_found && slot_v_q[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        grant = state_q == IDLE && gnt_found;
    end

    always_comb begin
        slot_v_d   = slot_v_q;
        slot_pot_d = slot_pot_q;
        slot_dt_d  = slot_dt_q;
        state_d    = state_q;
        last_d     = last_q;
        cmd_idx_d  = cmd_idx_q;
        cmd_pot_d  = cmd_pot_q;
        cmd_dt_d   = cmd_dt_q;
        if (grant) begin
            slot_v_d[gnt_idx] = 1'b0;
            state_d   = ISSUE;
            last_d    = gnt_idx;
            cmd_idx_d = gnt_idx;
            cmd_pot_d = slot_pot_q[gnt_idx];
            cmd_dt_d  = slot_dt_q[gnt_idx];
        end else if (state_q == ISSUE && cmd_ready) begin
            state_d = IDLE;
        end
        // a new event written after the grant clear survives in the slot
        for (int i = 0; i < N_SYN; i++) begin
            if (ev[i]) begin
                slot_v_d[i]   = 1'b1;
                slot_pot_d[i] = ev_pot[i];
                slot_dt_d[i]  = ev_dt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SYN; i++) begin
                t_pre_q[i]   <= ONES;
                t_post_q[i]  <= ONES;
                slot_dt_q[i] <= '0;
            end
            slot_v_q   <= '0;
            slot_pot_q <= '0;
            state_q    <= IDLE;
            last_q     <= IDX_W'(N_SYN - 1);
            cmd_idx_q  <= '0;
            cmd_pot_q  <= 1'b0;
            cmd_dt_q   <= '0;
        end else begin
            t_pre_q    <= t_pre_d;
            t_post_q   <= t_post_d;
            slot_dt_q  <= slot_dt_d;
            slot_v_q   <= slot_v_d;
            slot_pot_q <= slot_pot_d;
            state_q    <= state_d;
            last_q     <= last_d;
            cmd_idx_q  <= cmd_idx_d;
            cmd_pot_q  <= cmd_pot_d;
            cmd_dt_q   <= cmd_dt_d;
        end
    end

    assign cmd_valid = state_q == ISSUE;
    assign cmd_idx   = cmd_idx_q;
    assign cmd_pot   = cmd_pot_q;
    assign cmd_dt    = cmd_dt_q;
    assign busy      = |slot_v_q || cmd_valid;

`ifdef STDP_ARB_DROPCNT_EN
    logic [7:0] drop_q, drop_d;
    logic [4:0] n_drop;

    // an overwrite is an event landing on a slot that stays valid past this edge's grant
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < N_SYN; i++)
            n_drop = n_drop + 5'(ev[i] && slot_v_q[i] && !(grant && gnt_idx == IDX_W'(i)));
        drop_d = ({1'b0, drop_q} + 9'(n_drop) > 9'd255) ? 8'd255 : drop_q + 8'(n_drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_stdp_update_arbiter.sv
// tb_stdp_update_arbiter: directed and random checks of stdp_update_arbiter against a timestamp-based model
module tb_stdp_update_arbiter;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] pre_spike = '0;
    logic [3:0] post_spike = '0;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid, cmd_pot, busy;
    logic [1:0] cmd_idx;
    logic [7:0] cmd_dt, drop_cnt;

    always #5 clk = ~clk;

    stdp_update_arbiter #(.N_SYN(4), .IDX_W(2), .DT_WIDTH(8), .WINDOW(16)) dut (
        .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .post_spike(post_spike),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_idx(cmd_idx), .cmd_pot(cmd_pot),
        .cmd_dt(cmd_dt), .busy(busy), .drop_cnt(drop_cnt)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_pre [N];
    int last_post [N];
    bit pv [N];
    bit ppot [N];
    int pdt [N];
    bit m_issue, m_pot;
    int m_idx, m_dt, m_last, m_drop;
    int exp_drop1;

    function automatic int age(input int s);
        if (s < 0) return 255;
        return (cyc - s > 255) ? 255 : cyc - s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            last_pre[i] = -1;
            last_post[i] = -1;
            pv[i] = 0;
            ppot[i] = 0;
            pdt[i] = 0;
        end
        m_issue = 0; m_pot = 0; m_idx = 0; m_dt = 0; m_last = N - 1; m_drop = 0;
    endtask

    task automatic model_edge(input logic [3:0] p, input logic [3:0] q, input logic r);
        int g;
        bit ev, pot;
        int dt;
        g = -1;
        if (m_issue) begin
            if (r) m_issue = 0;
        end else begin
            for (int k = 1; k <= N; k++)
                if (g < 0 && pv[(m_last + k) % N]) g = (m_last + k) % N;
            if (g >= 0) begin
                m_issue = 1; m_idx = g; m_pot = ppot[g]; m_dt = pdt[g]; pv[g] = 0; m_last = g;
            end
        end
        for (int i = 0; i < N; i++) begin
            ev = 0; pot = 0; dt = 0;
            if (p[i] && q[i]) begin ev = 1; pot = 1; dt = 0; end
            else if (q[i] && age(last_pre[i]) < 16) begin ev = 1; pot = 1; dt = age(last_pre[i]); end
            else if (p[i] && age(last_post[i]) < 16) begin ev = 1; pot = 0; dt = age(last_post[i]); end
            if (ev) begin
                if (pv[i] && m_drop < 255) m_drop++;
                pv[i] = 1; ppot[i] = pot; pdt[i] = dt;
            end
            if (p[i]) last_pre[i] = cyc;
            if (q[i]) last_post[i] = cyc;
        end
        cyc++;
    endtask

    task automatic check_cycle();
        bit any;
        int ed;
        any = m_issue;
        for (int i = 0; i < N; i++) any = any | pv[i];
`ifdef STDP_ARB_DROPCNT_EN
        ed = m_drop;
`else
        ed = 0;
`endif
        chk("cmd_valid", cmd_valid, m_issue);
        chk("busy", busy, any);
        chk("drop_cnt", drop_cnt, ed);
        if (m_issue) begin
            chk("cmd_idx", cmd_idx, m_idx);
            chk("cmd_pot", cmd_pot, m_pot);
            chk("cmd_dt", cmd_dt, m_dt);
        end
    endtask

    task automatic step(input logic [3:0] p, input logic [3:0] q, input logic r);
        pre_spike = p; post_spike = q; cmd_ready = r;
        @(posedge clk);
        model_edge(p, q, r);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic do_reset();
        pre_spike = '0; post_spike = '0; cmd_ready = 1'b1; rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_valid", cmd_valid, 0);
        chk("rst_idx", cmd_idx, 0);
        chk("rst_pot", cmd_pot, 0);
        chk("rst_dt", cmd_dt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
    endtask

    initial begin
        logic [3:0] rp, rq;
`ifdef STDP_ARB_DROPCNT_EN
        exp_drop1 = 1;
`else
        exp_drop1 = 0;
`endif
        do_reset();

        // pre then post on synapse 0, dt 5
        step(4'b0001, 4'b0000, 1'b1);
        repeat (4) step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0001, 1'b1);
        chk("s1_busy", busy, 1);
        chk("s1_early", cmd_valid, 0);
        step(4'b0000, 4'b0000, 1'b1);
        chk("s1_valid", cmd_valid, 1);
        chk("s1_idx", cmd_idx, 0);
        chk("s1_pot", cmd_pot, 1);
        chk("s1_dt", cmd_dt, 5);
        step(4'b0000, 4'b0000, 1'b1);
        chk("s1_done", cmd_valid, 0);
        repeat (20) step(4'b0000, 4'b0000, 1'b1);

        // post then pre on synapse 2, depression dt 3
        step(4'b0000, 4'b0100, 1'b1);
        repeat (2) step(4'b0000, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        chk("s2_idx", cmd_idx, 2);
        chk("s2_pot", cmd_pot, 0);
        chk("s2_dt", cmd_dt, 3);
        repeat (20) step(4'b0000, 4'b0000, 1'b1);

        // coincident pair on 1; out-of-window pair on 3
        step(4'b1010, 4'b0010, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        chk("s3_idx", cmd_idx, 1);
        chk("s3_pot", cmd_pot, 1);
        chk("s3_dt", cmd_dt, 0);
        repeat (18) step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b1000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        chk("s3_nobusy", busy, 0);
        chk("s3_novalid", cmd_valid, 0);

        // all four synapses: grants 0,1,2,3 every 2 cycles
        do_reset();
        step(4'b1111, 4'b0000, 1'b1);
        step(4'b0000, 4'b1111, 1'b1);
        for (int g = 0; g < N; g++) begin
            step(4'b0000, 4'b0000, 1'b1);
            chk("s4_valid", cmd_valid, 1);
            chk("s4_idx", cmd_idx, g);
            chk("s4_dt", cmd_dt, 1);
            step(4'b0000, 4'b0000, 1'b1);
            chk("s4_gap", cmd_valid, 0);
        end
        repeat (20) step(4'b0000, 4'b0000, 1'b1);
        step(4'b1010, 4'b0000, 1'b1);
        step(4'b0000, 4'b1010, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        chk("s4b_first", cmd_idx, 1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        chk("s4b_second", cmd_idx, 3);
        chk("s4b_valid", cmd_valid, 1);

        // backpressure on idx 0 while synapse 1 is overwritten
        do_reset();
        step(4'b0001, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0001, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        chk("s5_valid", cmd_valid, 1);
        repeat (2) step(4'b0000, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 1'b0);
        repeat (3) step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0010, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        chk("s5_nodrop", drop_cnt, 0);
        step(4'b0000, 4'b0010, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        chk("s5_hold_idx", cmd_idx, 0);
        chk("s5_hold_dt", cmd_dt, 2);
        chk("s5_drop", drop_cnt, exp_drop1);
        step(4'b0000, 4'b0000, 1'b1);
        chk("s5_hs", cmd_valid, 0);
        step(4'b0000, 4'b0000, 1'b1);
        chk("s5_idx", cmd_idx, 1);
        chk("s5_pot", cmd_pot, 1);
        chk("s5_dt", cmd_dt, 6);

        // reset asserted mid-ISSUE with two slots pending
        do_reset();
        step(4'b0111, 4'b0000, 1'b0);
        step(4'b0000, 4'b0111, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        chk("s6_pre_valid", cmd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_valid", cmd_valid, 0);
        chk("s6_async_busy", busy, 0);
        do_reset();
        repeat (10) step(4'b0000, 4'b0000, 1'b1);
        chk("s6_quiet", busy, 0);
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0000, 4'b0001, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        chk("s6_new_idx", cmd_idx, 0);
        chk("s6_new_dt", cmd_dt, 1);

        // random traffic against the model
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                rp[i] = ($urandom_range(0, 7) == 0);
                rq[i] = ($urandom_range(0, 7) == 0);
            end
            step(rp, rq, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stdp_update_arbiter.md
# stdp_update_arbiter

Round-robin scheduler that shares one STDP weight-update engine among `N_SYN` synapses. It watches each synapse's pre/post spike lines and timestamps them with per-synapse saturating timers. Qualifying spike pairs become pending potentiation or depression events. The block then issues one command at a time to the shared engine over a valid/ready handshake. It sits between the LIF neuron array and the single weight-update/weight-storage datapath.

## Interface

Parameters:
- `N_SYN`, 4: number of synapses (power of two, 2..16)
- `IDX_W`, 2: `log2(N_SYN)`
- `DT_WIDTH`, 8: timer and `cmd_dt` width
- `WINDOW`, 16: STDP window; a pair qualifies only if `dt < WINDOW` (`WINDOW <= 2^DT_WIDTH - 1`)

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge
- `rst_n`, in, 1: reset, asynchronous, active-low
- `pre_spike`, in, `N_SYN`: 1-cycle presynaptic spike pulses, bit i = synapse i
- `post_spike`, in, `N_SYN`: 1-cycle postsynaptic spike pulses
- `cmd_valid`, out, 1: command presented to the engine
- `cmd_ready`, in, 1: engine accepts the command
- `cmd_idx`, out, `IDX_W`: synapse index
- `cmd_pot`, out, 1: 1 = potentiate, 0 = depress
- `cmd_dt`, out, `DT_WIDTH`: spike time difference in cycles
- `busy`, out, 1: any slot pending, or `cmd_valid` high
- `drop_cnt`, out, 8: overwritten-event count (see Configuration)

## Operation

**Timers.** Each synapse has two timers, `t_pre[i]` and `t_post[i]`.
- Reset value is all-ones, meaning "no recent spike".
- On the synapse's spike, the timer loads 1.
- Otherwise it increments, saturating at all-ones.
- A timer value is therefore the number of edges since that spike.

**Event detection** (uses pre-edge timer values):
- `post_spike[i]` only, with `t_pre[i] < WINDOW`: potentiation, `dt = t_pre[i]`.
- `pre_spike[i]` only, with `t_post[i] < WINDOW`: depression, `dt = t_post[i]`.
- Both in the same cycle: a single potentiation with `dt = 0`, and no depression.

**Pending slots.** One slot per synapse: {valid, pot, dt}.
- An event writes the slot.
- If the slot is already valid, the new event overwrites it and `drop_cnt` increments.

**FSM (IDLE, ISSUE).**
- IDLE: if any slot is valid, select the first valid slot searching from `last_grant+1` modulo `N_SYN`.
  - Load `cmd_idx`/`cmd_pot`/`cmd_dt` from that slot, clear the slot, set `last_grant`, and go to ISSUE.
  - If a new event targets the same slot in that same cycle, the new event remains in the slot. This does not count as a drop.
- ISSUE: `cmd_valid = 1`, and the cmd fields are held stable until `cmd_valid && cmd_ready`. On that handshake, go to IDLE.
- No arbitration occurs in ISSUE. Slots keep accumulating events.

**Reset.** `last_grant` resets to `N_SYN-1`, so synapse 0 wins first.

## Timing

- Reset values: `cmd_valid` = 0, `cmd_idx` = 0, `cmd_pot` = 0, `cmd_dt` = 0, `busy` = 0, `drop_cnt` = 0. State = IDLE, all slots invalid, timers all-ones.
- Latency with the FSM idle: spike sampled at edge t → slot valid after t → `cmd_valid` high after edge t+1.
- Throughput: at most one command per 2 cycles. IDLE is a mandatory cycle between commands.
- `cmd_ready` may be high before `cmd_valid`. The handshake occurs only on a cycle where both are high.
- `busy` is registered-consistent: it is high from the cycle after the slot write until the cycle after the final handshake.
- Reset asserted mid-ISSUE:
  - `cmd_valid` drops asynchronously.
  - Pending events are discarded.
  - No partial command is replayed.
- Timer saturation: a timer at all-ones never qualifies, because `WINDOW` is at most all-ones.

## Configuration

- `STDP_ARB_DROPCNT_EN` defined: `drop_cnt` is an 8-bit counter, saturating at 255, cleared only by reset.
- `STDP_ARB_DROPCNT_EN` undefined: `drop_cnt` is tied to 0 and the counter logic is not built.
- Overwrite behaviour is identical in both cases.

## Test plan

All scenarios use `N_SYN` = 4, `WINDOW` = 16, and `cmd_ready` = 1 unless stated.

- `pre_spike[0]` at edge 0, `post_spike[0]` at edge 5 → one command: idx 0, pot 1, dt 5. `cmd_valid` high after edge 6.
- `post_spike[2]` at edge 0, `pre_spike[2]` at edge 3 → idx 2, pot 0, dt 3.
- `pre_spike[1]` and `post_spike[1]` at the same edge, with no prior spikes → idx 1, pot 1, dt 0. `pre_spike[3]` at edge 0 and `post_spike[3]` at edge 20 → no command, `busy` stays 0.
- Pre on all 4 synapses, then post on all 4 at the same edge → grants in order 0, 1, 2, 3, every 2 cycles. Then events on synapses 1 and 3 together → 1 then 3.
- `cmd_ready` = 0 while issuing idx 0; two qualifying events on synapse 1 at edges 10 and 12 (dt 4, then dt 6):
  - cmd fields are held stable;
  - `drop_cnt` = 1 (0 with `STDP_ARB_DROPCNT_EN` undefined);
  - after ready, idx 1 issues with dt 6.
- Assert `rst_n` = 0 during ISSUE with two slots pending → `cmd_valid` = 0 immediately. After release, no commands issue until new spike pairs arrive.
